// File: rtl/int_to_flopoco_fp.sv
// int_to_flopoco_fp
//
// Converts a signed or unsigned integer into the FloPoCo floating-point
// format {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}. Rounding is
// round-to-nearest-even. Results that do not fit the exponent range become
// infinity. A valid strobe travels with the data through NUM_STAGES
// register ranks, and all ranks are stalled together by ce.
//
// Ranks: the first rank (NUM_STAGES >= 1) sits between normalisation and
// rounding. Any further ranks delay the packed result. With NUM_STAGES = 0
// the block is purely combinational.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valid, R, inexact)
//   ce         clock enable; 0 holds every rank including the valid chain
//   in_valid   X is valid this cycle
//   is_signed  1: X is two's complement, 0: X is unsigned
//   X          integer operand, IN_WIDTH bits
//   out_valid  R and inexact are valid
//   R          FloPoCo result, WE+WF+3 bits
//   inexact    nonzero bits were discarded by rounding, or the result overflowed
module int_to_flopoco_fp #(
   parameter int IN_WIDTH   = 32,
   parameter int WE         = 8,
   parameter int WF         = 23,
   parameter int NUM_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic                 is_signed,
   input  logic [IN_WIDTH-1:0]  X,
   output logic                 out_valid,
   output logic [WE+WF+2:0]     R,
   output logic                 inexact
);

   localparam int PW    = $clog2(IN_WIDTH);    // leading-one index width
   localparam int FBW   = IN_WIDTH - 1;        // bits below the leading one
   localparam int EW    = WE + 8;              // headroom for exponent overflow
   localparam int RW    = WE + WF + 3;
   localparam int EXT_W = FBW + WF + 3;        // fraction field padded for guard/sticky
   localparam int BIAS  = (32'd1 << (WE - 1)) - 32'd1;

   // Normalised operand handed from the first half to the rounding half.
   // A nonzero flag (rather than an is-zero flag) makes the all-zero reset
   // value decode to +zero.
   typedef struct packed {
      logic           vld;
      logic           nonzero;
      logic           sgn;
      logic [PW-1:0]  lead;
      logic [FBW-1:0] fb;
   } norm_t;

   typedef struct packed {
      logic          vld;
      logic [RW-1:0] r;
      logic          inx;
   } res_t;

   // ---------------------------------------------------------------- checks
   if (IN_WIDTH < 2 || IN_WIDTH > 64) begin : g_bad_in_width
      $error("int_to_flopoco_fp: IN_WIDTH must be in 2..64");
   end
   if (WE < 4 || WE > 11) begin : g_bad_we
      $error("int_to_flopoco_fp: WE must be in 4..11");
   end
   if (WF < 4 || WF > 52) begin : g_bad_wf
      $error("int_to_flopoco_fp: WF must be in 4..52");
   end
   if (NUM_STAGES < 0 || NUM_STAGES > 4) begin : g_bad_stages
      $error("int_to_flopoco_fp: NUM_STAGES must be in 0..4");
   end

   // ------------------------------------------------------ magnitude/normalise
   logic [IN_WIDTH:0]   xext_s;
   logic [IN_WIDTH:0]   mag_wide_s;
   logic [IN_WIDTH-1:0] mag_s;
   logic                neg_s;
   logic [PW-1:0]       lead_s;
   logic [PW-1:0]       shamt_s;
   norm_t               norm_comb_s;

   // Absolute value on IN_WIDTH+1 bits, leading-one search, left-align shift
   always_comb begin
      neg_s       = is_signed & X[IN_WIDTH-1];
      xext_s      = {neg_s, X};
      mag_wide_s  = neg_s ? (~xext_s + (IN_WIDTH+1)'(1'b1)) : xext_s;
      // The magnitude never exceeds 2^IN_WIDTH - 1, so the top bit is always 0.
      mag_s       = mag_wide_s[IN_WIDTH-1:0];
      lead_s      = '0;
      // Ascending scan: the last set bit seen is the leading one.
      for (int i = 0; i < IN_WIDTH; i++) begin
         lead_s = mag_s[i] ? PW'(i) : lead_s;
      end
      shamt_s     = PW'(FBW) - lead_s;
      norm_comb_s = '0;
      norm_comb_s.vld     = in_valid;
      norm_comb_s.nonzero = |mag_wide_s;
      norm_comb_s.sgn     = neg_s;
      norm_comb_s.lead    = lead_s;
      // Shifting the leading one out of the top leaves the fraction bits left-aligned.
      norm_comb_s.fb      = FBW'(mag_s << shamt_s);
   end

   norm_t norm_q_s;

   if (NUM_STAGES == 0) begin : g_rank1_none
      assign norm_q_s = norm_comb_s;
   end else begin : g_rank1
      norm_t norm_r;

      // First rank: normalised operand plus its valid bit
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            norm_r <= '0;
         end else if (ce) begin
            norm_r <= norm_comb_s;
         end
      end

      assign norm_q_s = norm_r;
   end

   // ------------------------------------------------------------- rounding
   logic [EXT_W-1:0] ext_s;
   logic [WF-1:0]    frac_t_s;
   logic             guard_s;
   logic             sticky_s;
   logic             round_up_s;
   logic [WF:0]      frac_sum_s;
   logic [EW-1:0]    exp_s;
   logic             ovf_s;
   res_t             res_comb_s;

   // Round to nearest even, exponent bias, overflow to infinity, pack
   always_comb begin
      ext_s      = {norm_q_s.fb, {(WF+3){1'b0}}};
      frac_t_s   = ext_s[EXT_W-1 -: WF];
      guard_s    = ext_s[EXT_W-1-WF];
      sticky_s   = |ext_s[EXT_W-2-WF:0];
      round_up_s = guard_s & (sticky_s | frac_t_s[0]);
      // A carry out of the fraction leaves its low WF bits all zero.
      frac_sum_s = {1'b0, frac_t_s} + (WF+1)'(round_up_s);
      exp_s      = EW'(norm_q_s.lead) + EW'(BIAS) + EW'(frac_sum_s[WF]);
      // The all-ones exponent is a normal value; only values beyond it overflow.
      ovf_s      = |exp_s[EW-1:WE];

      res_comb_s     = '0;
      res_comb_s.vld = norm_q_s.vld;
      if (!norm_q_s.nonzero) begin
         res_comb_s.r   = '0;
         res_comb_s.inx = 1'b0;
      end else if (ovf_s) begin
         res_comb_s.r   = {2'b10, norm_q_s.sgn, {WE{1'b0}}, {WF{1'b0}}};
         res_comb_s.inx = 1'b1;
      end else begin
         res_comb_s.r   = {2'b01, norm_q_s.sgn, exp_s[WE-1:0], frac_sum_s[WF-1:0]};
         res_comb_s.inx = guard_s | sticky_s;
      end
   end

   // -------------------------------------------------------- result ranks
   res_t res_q_s;

   if (NUM_STAGES <= 1) begin : g_res_none
      assign res_q_s = res_comb_s;
   end else begin : g_res_pipe
      res_t pipe_r [NUM_STAGES-1];

      // Remaining ranks: shift the packed result and its valid bit
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < NUM_STAGES - 1; i++) begin
               pipe_r[i] <= '0;
            end
         end else if (ce) begin
            pipe_r[0] <= res_comb_s;
            for (int i = 1; i < NUM_STAGES - 1; i++) begin
               pipe_r[i] <= pipe_r[i-1];
            end
         end
      end

      assign res_q_s = pipe_r[NUM_STAGES-2];
   end

   assign out_valid = res_q_s.vld;
   assign R         = res_q_s.r;
   assign inexact   = res_q_s.inx;

endmodule

// File: tb/tb_int_to_flopoco_fp.sv
// Directed self-checking bench for int_to_flopoco_fp.
// Five instances share the same inputs: single precision at NUM_STAGES
// 0/1/2/4, plus a WE=5/WF=10 instance for the overflow cases.
module tb_int_to_flopoco_fp;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        in_valid;
   logic        is_signed;
   logic [31:0] X;

   logic        ov0, ov1, ov2, ov4, ovh;
   logic [33:0] r0, r1, r2, r4;
   logic [17:0] rh;
   logic        i0, i1, i2, i4, ih;

   always #5 clk = ~clk;

   int_to_flopoco_fp #(.IN_WIDTH(32), .WE(8), .WF(23), .NUM_STAGES(0)) u_s0 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
      .X(X), .out_valid(ov0), .R(r0), .inexact(i0));
   int_to_flopoco_fp #(.IN_WIDTH(32), .WE(8), .WF(23), .NUM_STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
      .X(X), .out_valid(ov1), .R(r1), .inexact(i1));
   int_to_flopoco_fp #(.IN_WIDTH(32), .WE(8), .WF(23), .NUM_STAGES(2)) u_sp (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
      .X(X), .out_valid(ov2), .R(r2), .inexact(i2));
   int_to_flopoco_fp #(.IN_WIDTH(32), .WE(8), .WF(23), .NUM_STAGES(4)) u_s4 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
      .X(X), .out_valid(ov4), .R(r4), .inexact(i4));
   int_to_flopoco_fp #(.IN_WIDTH(32), .WE(5), .WF(10), .NUM_STAGES(2)) u_hp (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
      .X(X), .out_valid(ovh), .R(rh), .inexact(ih));

   int          n_checks = 0;
   int          n_pass   = 0;
   int          sidx    [4];
   logic [33:0] prev_r  [4];
   logic        prev_ov [4];
   logic [31:0] st_x    [8];
   logic [33:0] st_r    [8];
   logic [31:0] alt_x   [4];
   logic        alt_s   [4];
   logic [33:0] alt_r   [4];
   logic        alt_i   [4];
   logic        ce_was;
   int          k;

   function automatic logic [33:0] sp(input logic [1:0] e, input logic s,
                                      input logic [7:0] ex, input logic [22:0] f);
      return {e, s, ex, f};
   endfunction

   function automatic logic [17:0] hp(input logic [1:0] e, input logic s,
                                      input logic [4:0] ex, input logic [9:0] f);
      return {e, s, ex, f};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One operation through the NUM_STAGES=2 instances; returns at the sample
   // point where its result must be visible.
   task automatic single(input logic [31:0] x, input logic s);
      @(negedge clk);
      X = x; is_signed = s; in_valid = 1'b1; ce = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("not_early", 64'(ov2), 64'd0);
      @(negedge clk);
   endtask

   // Stream monitor for instance d: count results on enabled cycles, and
   // require frozen outputs on stalled cycles (registered instances only).
   task automatic chk_stream(input int d, input logic cew, input logic ov, input logic [33:0] r);
      if (cew && ov) begin
         chk($sformatf("stream%0d_extra", d), 64'(sidx[d] < 8), 64'd1);
         if (sidx[d] < 8) begin
            chk($sformatf("stream%0d_item%0d", d, sidx[d]), 64'(r), 64'(st_r[sidx[d]]));
         end
         sidx[d]++;
      end else if (!cew && d != 0) begin
         chk($sformatf("stream%0d_frozen_r", d), 64'(r), 64'(prev_r[d]));
         chk($sformatf("stream%0d_frozen_v", d), 64'(ov), 64'(prev_ov[d]));
      end
      prev_r[d]  = r;
      prev_ov[d] = ov;
   endtask

   initial begin
      rst = 1'b0; ce = 1'b0; in_valid = 1'b0; is_signed = 1'b0; X = 32'd0;
      #1 rst = 1'b1;

      // ---------------- reset state
      @(negedge clk);
      chk("rst_ov", 64'(ov2), 64'd0);
      chk("rst_r", 64'(r2), 64'd0);
      chk("rst_inx", 64'(i2), 64'd0);
      chk("rst_ov4", 64'(ov4), 64'd0);
      #2 rst = 1'b0; ce = 1'b1;

      // ---------------- single precision, signed
      single(32'h0000_0001, 1'b1);
      chk("one_v", 64'(ov2), 64'd1);
      chk("one_r", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd127, 23'd0)));
      chk("one_inx", 64'(i2), 64'd0);
      single(32'hFFFF_FFFF, 1'b1);
      chk("m1_r", 64'(r2), 64'(sp(2'b01, 1'b1, 8'd127, 23'd0)));
      chk("m1_inx", 64'(i2), 64'd0);
      single(32'h0000_0000, 1'b1);
      chk("zero_v", 64'(ov2), 64'd1);
      chk("zero_r", 64'(r2), 64'd0);
      chk("zero_inx", 64'(i2), 64'd0);

      // ---------------- rounding
      single(32'h0100_0001, 1'b1);
      chk("tie_even_r", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd151, 23'd0)));
      chk("tie_even_inx", 64'(i2), 64'd1);
      single(32'h0100_0003, 1'b1);
      chk("tie_up_r", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd151, 23'd2)));
      chk("tie_up_inx", 64'(i2), 64'd1);
      single(32'h7FFF_FFFF, 1'b1);
      chk("carry_r", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd158, 23'd0)));
      chk("carry_inx", 64'(i2), 64'd1);

      // ---------------- signedness
      single(32'h8000_0000, 1'b1);
      chk("minint_s_r", 64'(r2), 64'(sp(2'b01, 1'b1, 8'd158, 23'd0)));
      chk("minint_s_inx", 64'(i2), 64'd0);
      single(32'h8000_0000, 1'b0);
      chk("minint_u_r", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd158, 23'd0)));
      chk("minint_u_inx", 64'(i2), 64'd0);

      // back-to-back alternating mode
      alt_x[0] = 32'h8000_0000; alt_s[0] = 1'b1; alt_r[0] = sp(2'b01, 1'b1, 8'd158, 23'd0); alt_i[0] = 1'b0;
      alt_x[1] = 32'h8000_0000; alt_s[1] = 1'b0; alt_r[1] = sp(2'b01, 1'b0, 8'd158, 23'd0); alt_i[1] = 1'b0;
      alt_x[2] = 32'hFFFF_FFFF; alt_s[2] = 1'b1; alt_r[2] = sp(2'b01, 1'b1, 8'd127, 23'd0); alt_i[2] = 1'b0;
      alt_x[3] = 32'hFFFF_FFFF; alt_s[3] = 1'b0; alt_r[3] = sp(2'b01, 1'b0, 8'd159, 23'd0); alt_i[3] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk($sformatf("alt%0d_v", i - 2), 64'(ov2), 64'd1);
            chk($sformatf("alt%0d_r", i - 2), 64'(r2), 64'(alt_r[i-2]));
            chk($sformatf("alt%0d_inx", i - 2), 64'(i2), 64'(alt_i[i-2]));
         end
         if (i < 4) begin
            X = alt_x[i]; is_signed = alt_s[i]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end

      // ---------------- overflow, WE=5 WF=10
      single(32'h0001_0000, 1'b1);
      chk("hp_max_r", 64'(rh), 64'(hp(2'b01, 1'b0, 5'd31, 10'd0)));
      chk("hp_max_inx", 64'(ih), 64'd0);
      single(32'h0002_0000, 1'b1);
      chk("hp_ovf_r", 64'(rh), 64'(hp(2'b10, 1'b0, 5'd0, 10'd0)));
      chk("hp_ovf_inx", 64'(ih), 64'd1);
      single(32'h0000_FFF0, 1'b1);
      chk("hp_rndup_r", 64'(rh), 64'(hp(2'b01, 1'b0, 5'd31, 10'd0)));
      chk("hp_rndup_inx", 64'(ih), 64'd1);
      single(32'h0000_FFE0, 1'b1);
      chk("hp_exact_r", 64'(rh), 64'(hp(2'b01, 1'b0, 5'd30, 10'h3FF)));
      chk("hp_exact_inx", 64'(ih), 64'd0);
      single(32'hFFFE_0000, 1'b1);
      chk("hp_novf_r", 64'(rh), 64'(hp(2'b10, 1'b1, 5'd0, 10'd0)));
      chk("hp_novf_inx", 64'(ih), 64'd1);

      // ---------------- stall, 8 values, ce low for 3 cycles
      st_x[0] = 32'h0000_0001; st_r[0] = sp(2'b01, 1'b0, 8'd127, 23'd0);
      st_x[1] = 32'hFFFF_FFFF; st_r[1] = sp(2'b01, 1'b1, 8'd127, 23'd0);
      st_x[2] = 32'h0000_0003; st_r[2] = sp(2'b01, 1'b0, 8'd128, 23'h40_0000);
      st_x[3] = 32'h0100_0003; st_r[3] = sp(2'b01, 1'b0, 8'd151, 23'd2);
      st_x[4] = 32'h0000_0005; st_r[4] = sp(2'b01, 1'b0, 8'd129, 23'h20_0000);
      st_x[5] = 32'h8000_0000; st_r[5] = sp(2'b01, 1'b1, 8'd158, 23'd0);
      st_x[6] = 32'h0000_0007; st_r[6] = sp(2'b01, 1'b0, 8'd129, 23'h60_0000);
      st_x[7] = 32'h0000_0000; st_r[7] = 34'd0;
      is_signed = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
      end
      for (int d = 0; d < 4; d++) begin
         sidx[d] = 0; prev_r[d] = 34'd0; prev_ov[d] = 1'b0;
      end
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         ce_was = ce;
         chk_stream(0, ce_was, ov0, r0);
         chk_stream(1, ce_was, ov1, r1);
         chk_stream(2, ce_was, ov2, r2);
         chk_stream(3, ce_was, ov4, r4);
         if (c >= 4 && c <= 6) begin
            ce = 1'b0; X = st_x[4]; in_valid = 1'b1;
         end else begin
            ce = 1'b1;
            k  = (c < 4) ? c : c - 3;
            if (k < 8) begin
               X = st_x[k]; in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("stream%0d_count", d), 64'(sidx[d]), 64'd8);
      end

      // ---------------- asynchronous reset with operations in flight
      ce = 1'b1;
      @(negedge clk);
      X = 32'h0000_0001; in_valid = 1'b1;
      @(negedge clk);
      X = 32'h0000_0002;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_ov2", 64'(ov2), 64'd0);
      chk("arst_r2", 64'(r2), 64'd0);
      chk("arst_inx2", 64'(i2), 64'd0);
      chk("arst_ov4", 64'(ov4), 64'd0);
      chk("arst_r4", 64'(r4), 64'd0);
      @(negedge clk);
      chk("arst_hold_ov2", 64'(ov2), 64'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("flush%0d_ov1", i), 64'(ov1), 64'd0);
         chk($sformatf("flush%0d_ov2", i), 64'(ov2), 64'd0);
         chk($sformatf("flush%0d_ov4", i), 64'(ov4), 64'd0);
      end
      @(negedge clk);
      X = 32'h0000_0003; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_ov1", 64'(ov1), 64'd1);
      chk("post_r1", 64'(r1), 64'(sp(2'b01, 1'b0, 8'd128, 23'h40_0000)));
      chk("post_early_ov2", 64'(ov2), 64'd0);
      @(negedge clk);
      chk("post_ov2", 64'(ov2), 64'd1);
      chk("post_r2", 64'(r2), 64'(sp(2'b01, 1'b0, 8'd128, 23'h40_0000)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
